moore_bank: RTL and testbench

- Parametrised bank of N_CH independent Moore switch-tracking FSMs, one per switch group.
- Each channel advances only on enabled cycles (ctrl_in[i]).
- Adds three things per channel: a dwell timeout into a LOCK state, a change pulse, and a saturating transition counter.
- Sits between switch-input conditioning and the status/LED logic; any_active_o feeds the top-level indicator.

---
 rtl/moore_pkg.sv | 15 +
 rtl/moore_bank_if.sv | 25 ++
 rtl/moore_chan.sv | 79 +++++++
 rtl/moore_bank.sv | 40 ++++
 tb/tb_moore_bank.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/moore_pkg.sv
// moore_pkg: shared state encodings and sizing helper for the moore_bank switch-tracking FSMs
package moore_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] LOCK   = 2'd2;

    // Dwell counter must hold 0..DWELL_MAX-1; keep at least one bit when LOCK is disabled
    function automatic int dwell_w(input int dmax);
        return (dmax < 1) ? 1 : $clog2(dmax + 1);
    endfunction

endpackage

// File: rtl/moore_bank_if.sv
// moore_bank_if: switch/enable inputs and status outputs of the moore_bank channel array
interface moore_bank_if #(
    parameter int N_CH  = 4,
    parameter int SW_W  = 2,
    parameter int CNT_W = 8
);
    logic [N_CH*SW_W-1:0]  sw_in;
    logic [N_CH-1:0]       ctrl_in;
    logic                  clr_cnt;
    logic [N_CH-1:0]       active_o;
    logic [N_CH-1:0]       lock_o;
    logic [N_CH-1:0]       chg_o;
    logic [N_CH*CNT_W-1:0] trans_cnt;
    logic                  any_active_o;

    modport master (
        output sw_in, ctrl_in, clr_cnt,
        input  active_o, lock_o, chg_o, trans_cnt, any_active_o
    );

    modport slave (
        input  sw_in, ctrl_in, clr_cnt,
        output active_o, lock_o, chg_o, trans_cnt, any_active_o
    );
endinterface

// File: rtl/moore_chan.sv
// moore_chan: one switch-tracking channel with dwell timeout, change pulse and saturating transition count
module moore_chan
    import moore_pkg::*;
#(
    parameter int SW_W      = 2,
    parameter int DWELL_MAX = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SW_W-1:0]  sw_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic             active_o,
    output logic             lock_o,
    output logic             chg_o,
    output logic [CNT_W-1:0] cnt_o
);
    localparam int DW = dwell_w(DWELL_MAX);

    state_t           state_q, state_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic             chg_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             chg_d;

    // Next state: exit on sw[0] beats the dwell timeout; the unused encoding falls back to IDLE
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        if (en_i) begin
            case (state_q)
                IDLE: begin
                    if (|sw_i) begin
                        state_d = ACTIVE;
                        dwell_d = '0;
                    end
                end
                ACTIVE: begin
                    if (sw_i[0]) begin
                        state_d = IDLE;
                    end else if (DWELL_MAX != 0 && dwell_q == DW'(DWELL_MAX - 1)) begin
                        state_d = LOCK;
                        dwell_d = '0;
                    end else if (DWELL_MAX != 0) begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                LOCK:    state_d = (|sw_i) ? LOCK : IDLE;
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && state_q != ACTIVE && state_q != LOCK) begin
            state_d = IDLE;
        end
    end

    assign chg_d = (state_d != state_q);
    assign cnt_d = clr_i ? '0 : (chg_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    // State, dwell, change flag and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dwell_q <= '0;
            chg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            chg_q   <= chg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign active_o = (state_q == ACTIVE);
    assign lock_o   = (state_q == LOCK);
    assign chg_o    = chg_q;
    assign cnt_o    = cnt_q;
endmodule

// File: rtl/moore_bank.sv
// moore_bank: array of independent moore_chan channels with slice mapping and any-active reduction
module moore_bank
    import moore_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int SW_W      = 2,
    parameter int DWELL_MAX = 8,
    parameter int CNT_W     = 8
) (
    input  logic          clk,
    input  logic          reset,
    moore_bank_if.slave   bus
);
    logic [N_CH-1:0]       act, lck, chg;
    logic [N_CH*CNT_W-1:0] cnt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        moore_chan #(
            .SW_W      (SW_W),
            .DWELL_MAX (DWELL_MAX),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .sw_i     (bus.sw_in[i*SW_W +: SW_W]),
            .en_i     (bus.ctrl_in[i]),
            .clr_i    (bus.clr_cnt),
            .active_o (act[i]),
            .lock_o   (lck[i]),
            .chg_o    (chg[i]),
            .cnt_o    (cnt[i*CNT_W +: CNT_W])
        );
    end

    assign bus.active_o     = act;
    assign bus.lock_o       = lck;
    assign bus.chg_o        = chg;
    assign bus.trans_cnt    = cnt;
    assign bus.any_active_o = |act;
endmodule

// File: tb/tb_moore_bank.sv
// tb_moore_bank: directed test of two moore_bank builds (default, and CNT_W=2 with LOCK disabled) against a bench model
module tb_moore_bank;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sw_v = '0;
    logic [3:0] ctrl_v = '0;
    logic       clr_v = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    moore_bank_if #(.N_CH(4), .SW_W(2), .CNT_W(8)) ifa ();
    moore_bank_if #(.N_CH(4), .SW_W(2), .CNT_W(2)) ifb ();

    assign ifa.sw_in   = sw_v;
    assign ifa.ctrl_in = ctrl_v;
    assign ifa.clr_cnt = clr_v;
    assign ifb.sw_in   = sw_v;
    assign ifb.ctrl_in = ctrl_v;
    assign ifb.clr_cnt = clr_v;

    moore_bank #(.N_CH(4), .SW_W(2), .DWELL_MAX(8), .CNT_W(8)) ua (
        .clk(clk), .reset(reset), .bus(ifa.slave)
    );
    moore_bank #(.N_CH(4), .SW_W(2), .DWELL_MAX(0), .CNT_W(2)) ub (
        .clk(clk), .reset(reset), .bus(ifb.slave)
    );

    // Model: per build/channel, mode 0=idle 1=active 2=locked; stays = enabled stay cycles seen in active
    int  ms [2][4];
    int  mstay [2][4];
    int  mcnt [2][4];
    int  mchg [2][4];
    int  dm [2] = '{8, 0};
    int  cm [2] = '{255, 3};
    bit  armed = 1'b0;

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", n, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) begin
                automatic int s = ms[k][c];
                automatic int st = mstay[k][c];
                automatic int ns = s;
                automatic int nst = st;
                automatic int sw = int'(sw_v[c*2 +: 2]);
                if (ctrl_v[c]) begin
                    if (s == 0 && sw != 0) begin
                        ns = 1;
                        nst = 0;
                    end else if (s == 1 && sw % 2 == 1) begin
                        ns = 0;
                    end else if (s == 1 && dm[k] != 0) begin
                        nst = st + 1;
                        if (nst == dm[k]) begin
                            ns = 2;
                            nst = 0;
                        end
                    end else if (s == 2 && sw == 0) begin
                        ns = 0;
                    end
                end
                if (reset) begin
                    ms[k][c]    <= 0;
                    mstay[k][c] <= 0;
                    mcnt[k][c]  <= 0;
                    mchg[k][c]  <= 0;
                end else begin
                    ms[k][c]    <= ns;
                    mstay[k][c] <= nst;
                    mchg[k][c]  <= (ns != s) ? 1 : 0;
                    mcnt[k][c]  <= clr_v ? 0 : (ns != s) ? ((mcnt[k][c] + 1 > cm[k]) ? cm[k] : mcnt[k][c] + 1) : mcnt[k][c];
                end
            end
        end
        if (reset) armed <= 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            automatic int any_a = 0;
            automatic int any_b = 0;
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("a_active%0d", c), int'(ifa.active_o[c]), int'(ms[0][c] == 1));
                chk($sformatf("a_lock%0d", c),   int'(ifa.lock_o[c]),   int'(ms[0][c] == 2));
                chk($sformatf("a_chg%0d", c),    int'(ifa.chg_o[c]),    mchg[0][c]);
                chk($sformatf("a_cnt%0d", c),    int'(ifa.trans_cnt[c*8 +: 8]), mcnt[0][c]);
                chk($sformatf("b_active%0d", c), int'(ifb.active_o[c]), int'(ms[1][c] == 1));
                chk($sformatf("b_lock%0d", c),   int'(ifb.lock_o[c]),   int'(ms[1][c] == 2));
                chk($sformatf("b_chg%0d", c),    int'(ifb.chg_o[c]),    mchg[1][c]);
                chk($sformatf("b_cnt%0d", c),    int'(ifb.trans_cnt[c*2 +: 2]), mcnt[1][c]);
                if (ms[0][c] == 1) any_a = 1;
                if (ms[1][c] == 1) any_b = 1;
            end
            chk("a_any", int'(ifa.any_active_o), any_a);
            chk("b_any", int'(ifb.any_active_o), any_b);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(2);
        reset = 1'b0;
        chk("rst_a_active", int'(ifa.active_o), 0);
        chk("rst_a_cnt", int'(ifa.trans_cnt), 0);
        chk("rst_b_chg", int'(ifb.chg_o), 0);

        // ch0 enters ACTIVE, locks after 8 enabled stays (build A only)
        sw_v[1:0] = 2'b10;
        ctrl_v[0] = 1'b1;
        cyc(1);
        chk("t1_active0", int'(ifa.active_o[0]), 1);
        chk("t1_chg0", int'(ifa.chg_o[0]), 1);
        chk("t1_cnt0", int'(ifa.trans_cnt[7:0]), 1);
        cyc(7);
        chk("t1_chg0_drop", int'(ifa.chg_o[0]), 0);
        chk("t1_still_active0", int'(ifa.active_o[0]), 1);
        cyc(1);
        chk("t1_lock0", int'(ifa.lock_o[0]), 1);
        chk("t1_cnt0_2", int'(ifa.trans_cnt[7:0]), 2);
        chk("t1_b_nolock0", int'(ifb.lock_o[0]), 0);
        ctrl_v[0] = 1'b0;

        // ch1 at dwell 7 exits on sw[0] instead of locking
        sw_v[3:2] = 2'b10;
        ctrl_v[1] = 1'b1;
        cyc(8);
        chk("t2_active1", int'(ifa.active_o[1]), 1);
        sw_v[3:2] = 2'b11;
        cyc(1);
        chk("t2_idle1", int'(ifa.active_o[1]), 0);
        chk("t2_nolock1", int'(ifa.lock_o[1]), 0);
        chk("t2_cnt1", int'(ifa.trans_cnt[15:8]), 2);
        ctrl_v[1] = 1'b0;

        // ch2 with alternating enable: LOCK after 16 clocks
        sw_v[5:4] = 2'b10;
        ctrl_v[2] = 1'b1;
        cyc(1);
        for (int j = 0; j < 15; j++) begin
            ctrl_v[2] = j[0];
            cyc(1);
        end
        chk("t3_active2", int'(ifa.active_o[2]), 1);
        ctrl_v[2] = 1'b1;
        cyc(1);
        chk("t3_lock2", int'(ifa.lock_o[2]), 1);
        sw_v[5:4] = 2'b01;
        cyc(1);
        chk("t3_lock2_hold", int'(ifa.lock_o[2]), 1);
        sw_v[5:4] = 2'b00;
        cyc(1);
        chk("t3_idle2", int'(ifa.lock_o[2]), 0);
        chk("t3_cnt2", int'(ifa.trans_cnt[23:16]), 3);
        ctrl_v[2] = 1'b0;

        // ch3 toggles every enabled cycle: saturation in build B, then clear wins over a transition
        sw_v[7:6] = 2'b01;
        ctrl_v[3] = 1'b1;
        cyc(5);
        chk("t4_b_sat3", int'(ifb.trans_cnt[7:6]), 3);
        chk("t4_a_cnt3", int'(ifa.trans_cnt[31:24]), 5);
        clr_v = 1'b1;
        cyc(1);
        chk("t4_clr_a3", int'(ifa.trans_cnt[31:24]), 0);
        chk("t4_clr_b3", int'(ifb.trans_cnt[7:6]), 0);
        chk("t4_clr_chg3", int'(ifa.chg_o[3]), 1);
        clr_v = 1'b0;
        cyc(1);
        chk("t4_after_clr3", int'(ifb.trans_cnt[7:6]), 1);
        ctrl_v[3] = 1'b0;

        // reset with ch0 LOCK and ch1 ACTIVE, enables on
        sw_v[3:2] = 2'b10;
        ctrl_v[1] = 1'b1;
        cyc(1);
        chk("t5_pre_active1", int'(ifa.active_o[1]), 1);
        chk("t5_pre_lock0", int'(ifa.lock_o[0]), 1);
        ctrl_v[0] = 1'b1;
        reset = 1'b1;
        cyc(1);
        chk("t5_active", int'(ifa.active_o), 0);
        chk("t5_lock", int'(ifa.lock_o), 0);
        chk("t5_cnt", int'(ifa.trans_cnt), 0);
        chk("t5_any", int'(ifa.any_active_o), 0);
        chk("t5_b_any", int'(ifb.any_active_o), 0);
        reset = 1'b0;
        ctrl_v = 4'b0001;

        // 100 enabled stay cycles on ch0: build B never locks
        cyc(101);
        chk("t6_b_active0", int'(ifb.active_o[0]), 1);
        chk("t6_b_nolock", int'(ifb.lock_o), 0);
        chk("t6_a_lock0", int'(ifa.lock_o[0]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
